// File: rtl/alert_pkg.sv
// Shared types and constants for the alert handler ping scheduler.
// The LFSR constants only matter when ALERT_HANDLER_PING_SCHED_LFSR_EN is defined.
package alert_pkg;

    // Sparse state encoding, pairwise Hamming distance of at least 3
    typedef enum logic [4:0] {
        IDLE = 5'b00000,
        WAIT = 5'b11100,
        PING = 5'b00111
    } ping_sched_state_e;

    localparam int unsigned      PingSchedLfsrDw   = 16;
    localparam logic [15:0]      PingSchedLfsrTaps = 16'hB400;

    // One right-shifting Galois step
    function automatic logic [PingSchedLfsrDw-1:0] ping_sched_lfsr_step(
        input logic [PingSchedLfsrDw-1:0] s
    );
        logic [PingSchedLfsrDw-1:0] n;
        n = {1'b0, s[PingSchedLfsrDw-1:1]};
        if (s[0]) begin
            n = n ^ PingSchedLfsrTaps;
        end else begin
            n = n;
        end
        return n;
    endfunction

endpackage

// File: rtl/alert_handler_ping_sched_if.sv
// Ping handshake bundle between the scheduler (master) and the
// alert receivers / escalation senders (slave).
interface alert_handler_ping_sched_if #(
    parameter int NAlerts = 4,
    parameter int NEsc    = 4
);
    logic [NAlerts-1:0] alert_ping_req_o;
    logic [NEsc-1:0]    esc_ping_req_o;
    logic [NAlerts-1:0] alert_ping_ok_i;
    logic [NEsc-1:0]    esc_ping_ok_i;
    logic               alert_ping_fail_o;
    logic               esc_ping_fail_o;

    modport master (
        output alert_ping_req_o, esc_ping_req_o, alert_ping_fail_o, esc_ping_fail_o,
        input  alert_ping_ok_i, esc_ping_ok_i
    );

    modport slave (
        input  alert_ping_req_o, esc_ping_req_o, alert_ping_fail_o, esc_ping_fail_o,
        output alert_ping_ok_i, esc_ping_ok_i
    );
endinterface

// File: rtl/alert_handler_ping_sched_lfsr.sv
// 16-bit Galois LFSR that steps once per enable pulse; returns to its seed on reset.
// Only compiled when ALERT_HANDLER_PING_SCHED_LFSR_EN is defined.
`ifdef ALERT_HANDLER_PING_SCHED_LFSR_EN
module alert_handler_ping_sched_lfsr
    import alert_pkg::*;
#(
    parameter logic [15:0] Seed = 16'hACE1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       i_en,
    output logic [PingSchedLfsrDw-1:0] o_state
);
    logic [PingSchedLfsrDw-1:0] r_state;

    // LFSR state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= Seed;
        end else if (i_en) begin
            r_state <= ping_sched_lfsr_step(r_state);
        end else begin
            r_state <= r_state;
        end
    end

    assign o_state = r_state;
endmodule
`endif

// File: rtl/alert_handler_ping_sched.sv
// Round-robin liveness ping scheduler over alert receivers then escalation senders.
// Optional feature macro: ALERT_HANDLER_PING_SCHED_LFSR_EN (pseudo-random wait lengths).
module alert_handler_ping_sched
    import alert_pkg::*;
#(
    parameter int          NAlerts  = 4,
    parameter int          NEsc     = 4,
    parameter int          CntDw    = 16,
    parameter logic [15:0] LfsrSeed = 16'hACE1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic [NAlerts-1:0]         alert_ping_en_i,
    input  logic [CntDw-1:0]           wait_cyc_i,
    input  logic [CntDw-1:0]           timeout_cyc_i,
    output logic                       busy_o,
    alert_handler_ping_sched_if.master ping_if
);
    localparam int NTgt = NAlerts + NEsc;
    localparam int IdxW = $clog2(NTgt);
    localparam logic [IdxW-1:0] FirstEsc = IdxW'(NAlerts);

    ping_sched_state_e r_state, w_state_nxt;
    logic [IdxW-1:0]  r_idx, w_idx_nxt, w_first_idx, w_next_idx, w_pos;
    logic [CntDw-1:0] r_cnt, w_cnt_nxt, w_wait_val;
    logic [NTgt-1:0]  r_req_vec, w_req_vec_nxt, w_valid, w_ok_vec;
    logic             r_busy, w_ok, w_is_esc, w_found, w_alert_fail, w_esc_fail;

    assign w_valid  = {{NEsc{1'b1}}, alert_ping_en_i};
    assign w_ok_vec = {ping_if.esc_ping_ok_i, ping_if.alert_ping_ok_i};
    assign w_ok     = w_ok_vec[r_idx];
    assign w_is_esc = (r_idx >= FirstEsc);

`ifdef ALERT_HANDLER_PING_SCHED_LFSR_EN
    logic [PingSchedLfsrDw-1:0] w_lfsr;
    logic                       w_wait_entry;

    assign w_wait_entry = (w_state_nxt == WAIT) && (r_state != WAIT);

    alert_handler_ping_sched_lfsr #(.Seed(LfsrSeed)) u_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_en    (w_wait_entry),
        .o_state (w_lfsr)
    );

    assign w_wait_val = CntDw'(w_lfsr) & wait_cyc_i;
`else
    logic [15:0] w_unused_seed;
    assign w_unused_seed = LfsrSeed;
    assign w_wait_val    = wait_cyc_i;
`endif

    // First valid target at or after index 0
    always_comb begin
        w_first_idx = FirstEsc;
        for (int i = NTgt - 1; i >= 0; i--) begin
            if (w_valid[i]) begin
                w_first_idx = IdxW'(i);
            end else begin
                w_first_idx = w_first_idx;
            end
        end
    end

    // First valid target strictly after r_idx, wrapping around
    always_comb begin
        w_next_idx = FirstEsc;
        w_found    = 1'b0;
        w_pos      = r_idx;
        for (int k = 1; k <= NTgt; k++) begin
            w_pos = IdxW'((int'(r_idx) + k) % NTgt);
            if (!w_found && w_valid[w_pos]) begin
                w_next_idx = w_pos;
                w_found    = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state, counter and index update; fail decision needs this cycle's ok
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_alert_fail = 1'b0;
        w_esc_fail   = 1'b0;
        if (!en_i) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = {IdxW{1'b0}};
            w_cnt_nxt   = {CntDw{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = WAIT;
                    w_idx_nxt   = w_first_idx;
                    w_cnt_nxt   = w_wait_val;
                end
                WAIT: begin
                    if (r_cnt == {CntDw{1'b0}}) begin
                        w_state_nxt = PING;
                        w_cnt_nxt   = timeout_cyc_i;
                    end else begin
                        w_cnt_nxt = r_cnt - CntDw'(1);
                    end
                end
                PING: begin
                    if (w_ok || (r_cnt == {CntDw{1'b0}})) begin
                        w_alert_fail = !w_ok && !w_is_esc;
                        w_esc_fail   = !w_ok && w_is_esc;
                        w_state_nxt  = WAIT;
                        w_idx_nxt    = w_next_idx;
                        w_cnt_nxt    = w_wait_val;
                    end else begin
                        w_cnt_nxt = r_cnt - CntDw'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = {IdxW{1'b0}};
                    w_cnt_nxt   = {CntDw{1'b0}};
                end
            endcase
        end
    end

    // Request vector for the upcoming cycle
    always_comb begin
        w_req_vec_nxt = {NTgt{1'b0}};
        if (w_state_nxt == PING) begin
            w_req_vec_nxt[w_idx_nxt] = 1'b1;
        end else begin
            w_req_vec_nxt = {NTgt{1'b0}};
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_idx     <= {IdxW{1'b0}};
            r_cnt     <= {CntDw{1'b0}};
            r_req_vec <= {NTgt{1'b0}};
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_req_vec <= w_req_vec_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    assign ping_if.alert_ping_req_o  = r_req_vec[NAlerts-1:0];
    assign ping_if.esc_ping_req_o    = r_req_vec[NTgt-1:NAlerts];
    assign ping_if.alert_ping_fail_o = w_alert_fail;
    assign ping_if.esc_ping_fail_o   = w_esc_fail;
    assign busy_o                    = r_busy;
endmodule
